// File: rtl/serial_subtractor_if.sv
// Bus between a requester and serial_subtractor: operand request, status and result.
// start is a request sampled only while idle; done is a single-cycle pulse marking d/b/v valid.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b;
  logic             v;
  logic [1:0]       state;

  modport master (
    output start, x, y,
    input  busy, done, d, b, v, state
  );

  modport slave (
    input  start, x, y,
    output busy, done, d, b, v, state
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = X - Y, one bit per clock LSB first, with borrow and signed overflow.
// Operands are captured on an accepted start; results update on entry to DONE and hold until the next one.
module serial_subtractor #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, bb_q, r_q, d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q, b_q, v_q;
  logic             xm_q, ym_q;
  logic             busy_o, done_o;

  logic diff_bit, br_next, last_bit;

  assign diff_bit = a_q[0] ^ bb_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & bb_q[0]) | (~(a_q[0] ^ bb_q[0]) & br_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state, so busy/done are glitch-free
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      RUN:     busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath; the final bit is folded into d/b/v on the same edge that enters DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      bb_q  <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
      xm_q  <= 1'b0;
      ym_q  <= 1'b0;
      d_q   <= '0;
      b_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.x;
            bb_q  <= bus.y;
            xm_q  <= bus.x[WIDTH-1];
            ym_q  <= bus.y[WIDTH-1];
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          bb_q  <= bb_q >> 1;
          r_q   <= {diff_bit, r_q[WIDTH-1:1]};
          br_q  <= br_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            d_q <= {diff_bit, r_q[WIDTH-1:1]};
            b_q <= br_next;
            v_q <= (xm_q ^ ym_q) & (xm_q ^ diff_bit);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_o;
  assign bus.done  = done_o;
  assign bus.d     = d_q;
  assign bus.b     = b_q;
  assign bus.v     = v_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): hand-computed vectors, latency, reset and hold checks.
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full operation with latency checks; inputs driven and outputs sampled on negedges
  task automatic do_op(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [W-1:0] ed, input logic eb, input logic ev);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
      chk({tag, "_nodone"}, 8'(bus.done), 8'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 8'(bus.done), 8'd1);
    chk({tag, "_busy_in_done"}, 8'(bus.busy), 8'd0);
    chk({tag, "_d"}, 8'(bus.d), 8'(ed));
    chk({tag, "_b"}, 8'(bus.b), 8'(eb));
    chk({tag, "_v"}, 8'(bus.v), 8'(ev));
    @(negedge clk);
    chk({tag, "_done_drop"}, 8'(bus.done), 8'd0);
  endtask

  initial begin
    int done_cnt;
    int done_at[3];
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    rst = 1'b1;
    #12;
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_d", 8'(bus.d), 8'd0);
    chk("rst_bv", {6'd0, bus.b, bus.v}, 8'd0);
    chk("rst_state", 8'(bus.state), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("op1", 4'b0111, 4'b0010, 4'b0101, 1'b0, 1'b0);
    do_op("op2", 4'b0010, 4'b0111, 4'b1011, 1'b1, 1'b0);
    do_op("op3", 4'b1001, 4'b1111, 4'b1010, 1'b1, 1'b0);
    do_op("op4", 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);
    do_op("op5", 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b1);

    // start toggled and operands scrambled during RUN must not disturb the result
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 4'b1101;
    bus.y = 4'b0100;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x = 4'b0000;
    bus.y = 4'b1111;
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      bus.start = 1'(i % 2 == 0);
      bus.x = 4'($urandom_range(0, 15));
      bus.y = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("tog_done", 8'(bus.done), 8'd1);
    chk("tog_d", 8'(bus.d), 8'b1001);
    chk("tog_bv", {6'd0, bus.b, bus.v}, 8'd0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("tog_no_second_done", 8'(done_cnt), 8'd0);
    chk("tog_hold_d", 8'(bus.d), 8'b1001);
    chk("tog_hold_bv", {6'd0, bus.b, bus.v}, 8'd0);

    // Asynchronous reset two cycles into RUN
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 4'b0111;
    bus.y = 4'b0001;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 8'(bus.busy), 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 8'(bus.busy), 8'd0);
    chk("mid_rst_d", 8'(bus.d), 8'd0);
    chk("mid_rst_bv", {6'd0, bus.b, bus.v}, 8'd0);
    chk("mid_rst_state", 8'(bus.state), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("rst_no_done", 8'(done_cnt), 8'd0);

    do_op("eq", 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 4'b0001;
    bus.y = 4'b0010;
    done_cnt = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 18) bus.start = 1'b0;
      if (bus.done) begin
        if (done_cnt < 3) done_at[done_cnt] = i;
        done_cnt++;
        chk("b2b_d", 8'(bus.d), 8'b1111);
        chk("b2b_bv", {6'd0, bus.b, bus.v}, 8'b10);
      end
    end
    chk("b2b_count", 8'(done_cnt), 8'd3);
    if (done_cnt == 3) begin
      chk("b2b_first", 8'(done_at[0]), 8'd5);
      chk("b2b_second", 8'(done_at[1]), 8'd11);
      chk("b2b_third", 8'(done_at[2]), 8'd17);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing D = X − Y, one bit per clock, LSB first. It is the inverse-direction companion to the team's ripple-carry adders.
- Used where a full-width combinational subtractor is too costly, and as the borrow-chain reference for the adder/subtractor datapath work.
- Operands load on a start pulse. The result, borrow and signed-overflow flags appear with a one-cycle done pulse and hold until the next operation.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  minuend; captured on an accepted start.
- y  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- d  output  WIDTH  difference X − Y mod 2^WIDTH.
- b  output  1  borrow out (1 when X < Y unsigned).
- v  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy=0, done=0, d=0, b=0, v=0; internal shift registers, counter and borrow cleared. Applies immediately, including mid-RUN; the partial operation is discarded and done is never raised for it.
- FSM states:
  - IDLE: start=1 at a clock edge → capture x into A, y into B; borrow=0, count=0; state→RUN. start=0 → stay.
  - RUN: at each edge compute diff_i = A[0]^B[0]^br and br' = (~A[0]&B[0]) | (~(A[0]^B[0])&br). Shift A and B right by 1. Shift diff_i into the MSB of the result register R. Increment count. At the edge where count reaches WIDTH−1 (the WIDTH-th RUN edge), state→DONE.
  - DONE (one cycle): on entry, d←R, b←br, v←(Xmsb^Ymsb)&(Xmsb^R[WIDTH−1]), using the captured operand MSBs held in separate registers. Next edge → IDLE unconditionally.
- Registered outputs:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
- Latency: start sampled at edge 0. busy=1 after edges 0..WIDTH−1. done=1 for exactly one cycle following edge WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE: ignored, never queued. x/y changes after capture have no effect.
- d, b, v update only on entry to DONE. They hold their values through IDLE and the following RUN until the next DONE.
- start held high continuously: a new operation begins on the first edge in IDLE, i.e. back-to-back every WIDTH+2 cycles.
- Arithmetic: modulo 2^WIDTH. b is the unsigned borrow. v=1 iff the operands' signs differ and the result's sign differs from X's.
- X == Y gives d=0, b=0, v=0.

Test Plan (WIDTH=4):
- Reset, then start with x=0111, y=0010 → busy high for 4 cycles, then done pulses one cycle with d=0101, b=0, v=0; busy=0 during DONE.
- x=0010, y=0111 → d=1011, b=1, v=0. x=1001, y=1111 → d=1010, b=1, v=0.
- x=1000, y=0001 → d=0111, b=0, v=1. x=0111, y=1111 → d=1000, b=1, v=1.
- x=1101, y=0100 → d=1001, b=0, v=0. Toggle start and change x/y during RUN → result unchanged, no second done until start is re-issued in IDLE; d/b/v hold after done.
- Assert rst two cycles into RUN (asynchronously, mid-cycle) → outputs 0 immediately, no done pulse. After release, x=1111, y=1111 → d=0000, b=0, v=0.
- Hold start high for 3 operations (x=0001, y=0010) → done every 6 cycles, each with d=1111, b=1, v=0.
